pln_eval: RTL and testbench
===========================

# pln_eval

Postfix (reverse Polish) expression evaluator sitting downstream of the infix-to-postfix converter. It consumes the ASCII postfix token stream (single-digit operands, `* / + -`, terminator `=`) over a valid/ready handshake. It evaluates the expression on an internal operand stack and emits one signed result, or an error code, per `=`-terminated expression.

## Interface
- W, 16: operand/result width, signed two's complement.
- DEPTH, 16: operand stack depth in entries, ≥2.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_DAT  in  8  ASCII token.
- IN_VLD  in  1  IN_DAT valid.
- IN_RDY  out  1  block can accept a token; transfer occurs when IN_VLD & IN_RDY at a rising edge.
- RES_DAT  out  W  result value; holds its value between results.
- RES_VLD  out  1  one-cycle pulse; RES_DAT, RES_ERR and ERR_CODE are valid while it is high.
- RES_ERR  out  1  the expression failed; RES_DAT is 0 in that case.
- ERR_CODE  out  3  0 none, 1 stack underflow, 2 stack overflow, 3 divide by zero, 4 illegal character, 5 leftover operands.

## Operation
- Token classes:
  - '0'..'9' (48..57): operand, value = code−48, zero-extended to W.
  - 42 `*`, 47 `/`, 43 `+`, 45 `-`: binary operator.
  - 61 `=`: end of expression.
  - 32 (space): ignored, consumes no cycle beyond the transfer.
  - any other code: illegal.
- Stack: register array of DEPTH×W with pointer sp, range 0..DEPTH. Element sp−1 is the top (B); sp−2 is A.
- States:
  - IDLE: IN_RDY=1.
    - Operand: if sp==DEPTH → ERR (code 2); else push it, stay in IDLE.
    - Operator: if sp<2 → ERR (code 1); else latch opcode → EXEC.
    - `=`: sp==0 → ERR-terminate (code 1); sp>1 → ERR-terminate (code 5); sp==1 → RESULT with value stack[0].
    - Illegal: → ERR (code 4).
  - EXEC: IN_RDY=0. Compute A op B, write it to entry sp−2, sp←sp−1 → IDLE.
    - Divide with B==0: → ERR (code 3), stack unchanged.
  - RESULT: IN_RDY=0. RES_VLD=1, RES_ERR=0, ERR_CODE=0, RES_DAT=value. sp←0 → IDLE.
  - ERR: IN_RDY=1. All tokens are accepted and discarded until `=`; then → RESULT with RES_ERR=1, RES_DAT=0 and the latched code. Only the first error code of an expression is kept.
  - "ERR-terminate" on `=`: enter RESULT directly with the error flagged.
- Arithmetic, all modulo 2^W:
  - `+` and `-` wrap.
  - `*` keeps the low W bits of the signed product.
  - `/` is signed, truncates toward zero, remainder discarded; −2^(W−1) / −1 yields −2^(W−1).
- Operand order: A is the earlier operand. "73-" gives 4 and "73/" gives 2.

## Timing
- Reset values: IN_RDY=0 while RST_N is low and 1 from the first edge after release. State IDLE, sp=0, RES_DAT=0, RES_VLD=0, RES_ERR=0, ERR_CODE=0.
- Operand accepted: pushed at that edge. IN_RDY stays high, so back-to-back operands run at one per cycle.
- Operator accepted at edge n: EXEC during cycle n+1 with IN_RDY=0. The result is on the stack at edge n+1, and IN_RDY is 1 again in cycle n+2.
- `=` accepted at edge n: RES_VLD=1 during cycle n+1 only, with IN_RDY=0. The next token can be accepted at edge n+2.
- Result latency: `=` transfer edge to RES_VLD = 1 cycle.
- IN_DAT is sampled only on a transfer edge. IN_VLD=0 cycles are idle and change nothing.
- RST_N asserted mid-expression or during EXEC/RESULT: immediate return to reset values. A pending RES_VLD pulse is lost and the stack is cleared. No output is produced for the partial expression.
- The stack is never read out of range. Underflow and overflow are detected before any access.

## Test plan
- "34+=": RES_VLD once, RES_DAT=7, RES_ERR=0. IN_RDY is low for exactly 1 cycle after `+` and 1 cycle after `=`.
- "92-3*=" then "27-=": first RES_DAT=21, then RES_DAT=0xFFFB (−5). Confirms sp resets between expressions with no gap token.
- "72/=" → 3. "50/=" → RES_ERR=1, ERR_CODE=3, RES_DAT=0. "3+=" → ERR_CODE=1. "34=" → ERR_CODE=5. "3a4+=" → ERR_CODE=4, and the trailing tokens are absorbed with IN_RDY=1.
- DEPTH+1 consecutive digits then "=" → ERR_CODE=2, one RES_VLD only. The following "1 1 +=" returns 2, showing spaces are ignored and the block recovers.
- Wrap: with W=16, "99*9*9*9*9*=" → low 16 bits of 9^6=531441, i.e. 0x1BF1. Random IN_VLD gaps give identical results.
- Drive "12+" then pull RST_N low for 1 cycle, then send "5=": RES_DAT=5, RES_ERR=0. All outputs read as reset values while RST_N is low.

Source files
------------

// File: rtl/pln_eval.sv
// Postfix (RPN) expression evaluator: consumes ASCII tokens over valid/ready,
// evaluates on an operand stack, emits one result or error code per '='.
module pln_eval #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_dat_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  output logic [W-1:0] res_dat_o,
  output logic         res_vld_o,
  output logic         res_err_o,
  output logic [2:0]   err_code_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESULT, ERR} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  localparam logic [2:0] E_NONE = 3'd0, E_UNDER = 3'd1, E_OVER = 3'd2,
                         E_DIV0 = 3'd3, E_ILL   = 3'd4, E_LEFT = 3'd5;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [2:0]       err_q, err_d;
  logic [W-1:0]     res_dat_q, res_dat_d;
  logic             res_err_q, res_err_d;
  logic [2:0]       code_q, code_d;
  logic             rdy_en_q;
  logic [W-1:0]     stk_q [DEPTH];

  logic             we;
  logic [AW-1:0]    waddr;
  logic [W-1:0]     wdata;

  // Token decode
  logic       xfer, is_dig, is_op, is_eq, is_sp;
  op_e        tok_op;
  logic [W-1:0] dig_val;
  logic [7:0] dig_raw;

  assign xfer    = in_vld_i & in_rdy_o;
  assign is_dig  = (in_dat_i >= 8'd48) && (in_dat_i <= 8'd57);
  assign is_eq   = (in_dat_i == 8'd61);
  assign is_sp   = (in_dat_i == 8'd32);
  assign dig_raw = in_dat_i - 8'd48;
  assign dig_val = W'(dig_raw);

  always_comb begin
    is_op  = 1'b1;
    tok_op = OP_ADD;
    case (in_dat_i)
      8'd43:   tok_op = OP_ADD;
      8'd45:   tok_op = OP_SUB;
      8'd42:   tok_op = OP_MUL;
      8'd47:   tok_op = OP_DIV;
      default: is_op  = 1'b0;
    endcase
  end

  // Operand access: B is the top of stack, A just below it
  logic [SPW-1:0] sp_m1, sp_m2;
  logic [AW-1:0]  idx_a, idx_b, idx_push;
  logic [W-1:0]   opa, opb, prod, quot, alu;

  assign sp_m1    = sp_q - SPW'(1);
  assign sp_m2    = sp_q - SPW'(2);
  assign idx_b    = sp_m1[AW-1:0];
  assign idx_a    = sp_m2[AW-1:0];
  assign idx_push = sp_q[AW-1:0];
  assign opa      = stk_q[idx_a];
  assign opb      = stk_q[idx_b];
  assign prod     = opa * opb;

  // Signed truncating divide; -1 handled as negation so MIN/-1 wraps to MIN
  always_comb begin
    quot = '0;
    if (opb == '1)
      quot = '0 - opa;
    else if (opb != '0)
      quot = W'($signed(opa) / $signed(opb));
  end

  always_comb begin
    case (op_q)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_MUL:  alu = prod;
      default: alu = quot;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sp_d      = sp_q;
    err_d     = err_q;
    res_dat_d = res_dat_q;
    res_err_d = res_err_q;
    code_d    = code_q;
    we        = 1'b0;
    waddr     = idx_push;
    wdata     = dig_val;
    case (state_q)
      IDLE: if (xfer && !is_sp) begin
        if (is_dig) begin
          if (sp_q == SPW'(DEPTH)) begin
            err_d   = E_OVER;
            state_d = ERR;
          end else begin
            we   = 1'b1;
            sp_d = sp_q + SPW'(1);
          end
        end else if (is_op) begin
          if (sp_q < SPW'(2)) begin
            err_d   = E_UNDER;
            state_d = ERR;
          end else begin
            op_d    = tok_op;
            state_d = EXEC;
          end
        end else if (is_eq) begin
          state_d = RESULT;
          if (sp_q == SPW'(1)) begin
            res_dat_d = stk_q[0];
            res_err_d = 1'b0;
            code_d    = E_NONE;
          end else begin
            res_dat_d = '0;
            res_err_d = 1'b1;
            code_d    = (sp_q == '0) ? E_UNDER : E_LEFT;
          end
        end else begin
          err_d   = E_ILL;
          state_d = ERR;
        end
      end
      EXEC: begin
        if (op_q == OP_DIV && opb == '0) begin
          err_d   = E_DIV0;
          state_d = ERR;
        end else begin
          we      = 1'b1;
          waddr   = idx_a;
          wdata   = alu;
          sp_d    = sp_m1;
          state_d = IDLE;
        end
      end
      RESULT: begin
        sp_d    = '0;
        state_d = IDLE;
      end
      default: if (xfer && is_eq) begin
        res_dat_d = '0;
        res_err_d = 1'b1;
        code_d    = err_q;
        state_d   = RESULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      sp_q      <= '0;
      err_q     <= E_NONE;
      res_dat_q <= '0;
      res_err_q <= 1'b0;
      code_q    <= E_NONE;
      rdy_en_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      res_dat_q <= res_dat_d;
      res_err_q <= res_err_d;
      code_q    <= code_d;
      rdy_en_q  <= 1'b1;
      if (we) stk_q[waddr] <= wdata;
    end
  end

  assign in_rdy_o   = rdy_en_q & ((state_q == IDLE) | (state_q == ERR));
  assign res_vld_o  = (state_q == RESULT);
  assign res_dat_o  = res_dat_q;
  assign res_err_o  = res_err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_pln_eval.sv
// Directed bench for pln_eval: expected results queued per expression and
// compared by a monitor whenever a result pulse appears.
module tb_pln_eval;
  localparam int W = 16, DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_dat = 8'd32;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] res_dat;
  logic         res_vld, res_err;
  logic [2:0]   err_code;

  pln_eval #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_dat_i(in_dat), .in_vld_i(in_vld),
    .in_rdy_o(in_rdy), .res_dat_o(res_dat), .res_vld_o(res_vld),
    .res_err_o(res_err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] dat; logic err; logic [2:0] code; string tag; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  bit gaps = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && res_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".dat"}, 32'(res_dat), 32'(e.dat));
        chk({e.tag, ".err"}, 32'(res_err), 32'(e.err));
        chk({e.tag, ".code"}, 32'(err_code), 32'(e.code));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input byte c);
    int n;
    in_dat = c;
    in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rdy_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_vld = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] d,
                            input logic er, input logic [2:0] cd);
    exp_t e;
    e.dat = d; e.err = er; e.code = cd; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input string tag, input string s, input logic [W-1:0] d,
                     input logic er, input logic [2:0] cd);
    expect_res(tag, d, er, cd);
    send_str(s);
  endtask

  initial begin
    logic [31:0] pw;
    string ovf;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(in_rdy), 32'd0);
    chk("rst_vld", 32'(res_vld), 32'd0);
    chk("rst_dat", 32'(res_dat), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_rdy), 32'd1);

    // "34+=" with ready-gap checks
    expect_res("add", 16'd7, 1'b0, 3'd0);
    send("3"); send("4"); send("+");
    chk("rdy_exec", 32'(in_rdy), 32'd0);
    @(negedge clk);
    chk("rdy_after_exec", 32'(in_rdy), 32'd1);
    send("=");
    chk("rdy_result", 32'(in_rdy), 32'd0);
    chk("vld_result", 32'(res_vld), 32'd1);
    @(negedge clk);
    chk("rdy_after_result", 32'(in_rdy), 32'd1);
    chk("vld_one_cycle", 32'(res_vld), 32'd0);
    chk("dat_hold", 32'(res_dat), 32'd7);

    run("sub_mul", "92-3*=", 16'd21, 1'b0, 3'd0);
    run("neg", "27-=", 16'hFFFB, 1'b0, 3'd0);
    run("order_sub", "73-=", 16'd4, 1'b0, 3'd0);
    run("order_div", "73/=", 16'd2, 1'b0, 3'd0);
    run("div", "72/=", 16'd3, 1'b0, 3'd0);
    run("div_neg_trunc", "07-2/=", 16'hFFFD, 1'b0, 3'd0);
    run("div0", "50/=", 16'd0, 1'b1, 3'd3);
    run("underflow", "3+=", 16'd0, 1'b1, 3'd1);
    run("empty_eq", "=", 16'd0, 1'b1, 3'd1);
    run("leftover", "34=", 16'd0, 1'b1, 3'd5);

    expect_res("illegal", 16'd0, 1'b1, 3'd4);
    send("3"); send("a");
    chk("rdy_in_err", 32'(in_rdy), 32'd1);
    send("4");
    chk("rdy_in_err2", 32'(in_rdy), 32'd1);
    send("+"); send("=");

    ovf = "";
    for (int i = 0; i <= DEPTH; i++) ovf = {ovf, "1"};
    run("overflow", {ovf, "="}, 16'd0, 1'b1, 3'd2);
    run("recover", "1 1 +=", 16'd2, 1'b0, 3'd0);

    pw = 32'd9 ** 6;
    run("wrap", "99*9*9*9*9*=", pw[W-1:0], 1'b0, 3'd0);
    gaps = 1'b1;
    run("wrap_gaps", "99*9*9*9*9*=", pw[W-1:0], 1'b0, 3'd0);
    run("sub_mul_gaps", "92-3*=", 16'd21, 1'b0, 3'd0);
    gaps = 1'b0;

    // Reset mid-expression, during EXEC
    send_str("12+");
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(in_rdy), 32'd0);
    chk("midrst_vld", 32'(res_vld), 32'd0);
    chk("midrst_dat", 32'(res_dat), 32'd0);
    chk("midrst_err", 32'(res_err), 32'd0);
    chk("midrst_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", "5=", 16'd5, 1'b0, 3'd0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
